// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, reverse double-dabble correction constants
// and the converter state encoding.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX        = 4'd9;
  localparam bcd_digit_t BCD_RDD_THRESH = 4'd8;
  localparam bcd_digit_t BCD_RDD_ADJ    = 4'd3;

  localparam int BCD_DIGITS = 3;
  localparam int RDD_BIN_W  = 10;
  localparam int RDD_W      = BCD_DIGITS * 4 + RDD_BIN_W;
  localparam int RDD_STEPS  = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_FIX,
    ST_DONE
  } state_e;

  function automatic logic is_bad_digit(input bcd_digit_t d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_rdd_step.sv
// One reverse double-dabble step: shift right, then pull each BCD nibble
// that reached 8 or more back down by 3 (no borrow across nibbles).
module bcd_rdd_step
  import bcd_pkg::*;
(
  input  logic [RDD_W-1:0] din,
  output logic [RDD_W-1:0] dout
);

  logic [RDD_W-1:0] shifted;
  bcd_digit_t       nib;

  always_comb begin
    shifted = din >> 1;
    dout    = shifted;
    nib     = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      nib = shifted[RDD_BIN_W + 4*i +: 4];
      if (nib >= BCD_RDD_THRESH) begin
        dout[RDD_BIN_W + 4*i +: 4] = nib - BCD_RDD_ADJ;
      end
    end
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential signed 3-digit BCD to two's-complement converter, one RDD step per clock.
// Define BCD2BIN_SAT_EN to saturate out_bin on overflow instead of wrapping.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [3:0]              in_bcd_h,
  input  logic [3:0]              in_bcd_t,
  input  logic [3:0]              in_bcd_o,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_bin,
  output logic                    out_ovf,
  output logic                    out_bad_digit
);

  typedef logic [RDD_BIN_W-1:0] mag_t;

  localparam mag_t       POS_LIM   = mag_t'(2**(OUT_W-1) - 1);
  localparam mag_t       NEG_LIM   = mag_t'(2**(OUT_W-1));
  localparam logic [3:0] LAST_STEP = 4'(RDD_STEPS - 1);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [RDD_W-1:0]        sreg_q, sreg_d;
  logic                    sign_q, sign_d;
  logic                    bad_q, bad_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_bin_q, out_bin_d;
  logic                    out_ovf_q, out_ovf_d;
  logic                    out_bad_q, out_bad_d;

  logic [RDD_W-1:0]        step_out;
  mag_t                    mag;
  logic [OUT_W-1:0]        mag_lo;
  logic signed [OUT_W-1:0] wrapped;
  logic signed [OUT_W-1:0] result;
  logic                    ovf;

`ifdef BCD2BIN_SAT_EN
  function automatic logic signed [OUT_W-1:0] saturate(
    input logic signed [OUT_W-1:0] val,
    input logic                    over,
    input logic                    neg
  );
    if (!over) return val;
    return neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  endfunction
`endif

  bcd_rdd_step u_step (
    .din  (sreg_q),
    .dout (step_out)
  );

  // Low OUT_W bits of the negated magnitude equal the wrapped 11-bit result.
  always_comb begin
    mag     = sreg_q[RDD_BIN_W-1:0];
    mag_lo  = mag[OUT_W-1:0];
    wrapped = sign_q ? -mag_lo : mag_lo;
    ovf     = !bad_q && (sign_q ? (mag > NEG_LIM) : (mag > POS_LIM));
`ifdef BCD2BIN_SAT_EN
    result  = saturate(wrapped, ovf, sign_q);
`else
    result  = wrapped;
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sreg_d      = sreg_q;
    sign_d      = sign_q;
    bad_d       = bad_q;
    out_valid_d = out_valid_q;
    out_bin_d   = out_bin_q;
    out_ovf_d   = out_ovf_q;
    out_bad_d   = out_bad_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_CONV;
          cnt_d   = '0;
          sreg_d  = {in_bcd_h, in_bcd_t, in_bcd_o, {RDD_BIN_W{1'b0}}};
          sign_d  = in_sign;
          bad_d   = is_bad_digit(in_bcd_h) | is_bad_digit(in_bcd_t) |
                    is_bad_digit(in_bcd_o);
        end
      end
      ST_CONV: begin
        sreg_d = step_out;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LAST_STEP) state_d = ST_FIX;
      end
      ST_FIX: begin
        out_bin_d   = bad_q ? '0 : result;
        out_ovf_d   = ovf;
        out_bad_d   = bad_q;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_bad_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
      out_ovf_q   <= out_ovf_d;
      out_bad_q   <= out_bad_d;
    end
  end

  // Operand datapath is always loaded before use, so it carries no reset.
  always_ff @(posedge clk) begin
    sreg_q <= sreg_d;
    sign_q <= sign_d;
    bad_q  <= bad_d;
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = out_valid_q;
  assign out_bin       = out_bin_q;
  assign out_ovf       = out_ovf_q;
  assign out_bad_digit = out_bad_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed vector table, corner sequences
// and a shuffled sweep of every signed 3-digit value against an arithmetic model.
module tb_bcd2bin_seq;

  localparam int OUT_W = 8;
  localparam int MAXP  = 2**(OUT_W-1) - 1;
  localparam int MINN  = -(2**(OUT_W-1));
`ifdef BCD2BIN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [3:0]       in_bcd_h, in_bcd_t, in_bcd_o;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_bin;
  logic             out_ovf;
  logic             out_bad_digit;

  int checks = 0;
  int errors = 0;

  bcd2bin_seq #(.OUT_W(OUT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_bcd_h      (in_bcd_h),
    .in_bcd_t      (in_bcd_t),
    .in_bcd_o      (in_bcd_o),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_bin       (out_bin),
    .out_ovf       (out_ovf),
    .out_bad_digit (out_bad_digit)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic             sg;
    logic [3:0]       h, t, o;
    logic [OUT_W-1:0] eb;
    logic             eo, ebad;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic sg, input logic [3:0] dh, input logic [3:0] dt,
                                input logic [3:0] dd, output logic [OUT_W-1:0] eb,
                                output logic eo, output logic ebad);
    int mag, v;
    ebad = (dh > 4'd9) || (dt > 4'd9) || (dd > 4'd9);
    mag  = int'(dh) * 100 + int'(dt) * 10 + int'(dd);
    v    = sg ? -mag : mag;
    eo   = !ebad && (v > MAXP || v < MINN);
    if (ebad)          eb = '0;
    else if (eo && SAT) eb = OUT_W'((v > 0) ? MAXP : MINN);
    else               eb = OUT_W'(v);
  endfunction

  task automatic run_op(input string tag, input logic sg, input logic [3:0] dh,
                        input logic [3:0] dt, input logic [3:0] dd,
                        input logic [OUT_W-1:0] eb, input logic eo, input logic ebad,
                        input int hold, input bit rdy_early);
    int k, lat;
    logic [OUT_W-1:0] b0;
    k = 0;
    while (!in_ready && k < 40) begin
      @(posedge clk); #1; k++;
    end
    check({tag, " in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; in_sign = sg; in_bcd_h = dh; in_bcd_t = dt; in_bcd_o = dd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sign  = 1'($urandom);
    in_bcd_h = 4'($urandom); in_bcd_t = 4'($urandom); in_bcd_o = 4'($urandom);
    if (rdy_early) out_ready = 1'b1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, " latency"}, lat, 11);
    check({tag, " out_bin"}, out_bin, eb);
    check({tag, " out_ovf"}, out_ovf, eo);
    check({tag, " out_bad_digit"}, out_bad_digit, ebad);
    check({tag, " in_ready_busy"}, in_ready, 0);
    b0 = out_bin;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
      check({tag, " hold_valid"}, out_valid, 1);
      check({tag, " hold_bin"}, out_bin, b0);
      check({tag, " hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid_drop"}, out_valid, 0);
    check({tag, " in_ready_back"}, in_ready, 1);
  endtask

  vec_t vecs[$];
  int   vals[$];

  initial begin
    logic [OUT_W-1:0] eb;
    logic             eo, ebad, sg;
    logic [3:0]       dh, dt, dd;
    int               mag, j, tmp, k;

    vecs.push_back('{1'b0, 4'd1, 4'd2, 4'd7, 8'h7F, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'd1, 4'd2, 4'd8, 8'h80, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd2, 4'd0, 4'd0, SAT ? 8'h7F : 8'hC8, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'd9, 4'd9, 4'd9, SAT ? 8'h80 : 8'h19, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'd1, 4'd2, 4'd9, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'd1, 4'd2, 4'd8, SAT ? 8'h7F : 8'h80, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 4'hA, 4'd3, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'hF, 4'd0, 4'd0, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'd0, 4'd0, 4'd1, 8'hFF, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'd0, 4'd4, 4'd2, 8'h2A, 1'b0, 1'b0});

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_sign = 1'b0;
    in_bcd_h = '0; in_bcd_t = '0; in_bcd_o = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_bin", out_bin, 0);
    check("rst out_ovf", out_ovf, 0);
    check("rst out_bad_digit", out_bad_digit, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].sg, vecs[i].h, vecs[i].t, vecs[i].o,
             vecs[i].eb, vecs[i].eo, vecs[i].ebad, 0, 1'b0);

    // backpressure then an immediate back-to-back operand
    run_op("bp", 1'b0, 4'd0, 4'd4, 4'd2, 8'h2A, 1'b0, 1'b0, 5, 1'b0);
    run_op("b2b", 1'b0, 4'd1, 4'd0, 4'd0, 8'h64, 1'b0, 1'b0, 0, 1'b0);
    run_op("rdy_early", 1'b1, 4'd0, 4'd5, 4'd5, 8'hC9, 1'b0, 1'b0, 0, 1'b1);

    // reset during CONV step 5
    in_valid = 1'b1; in_sign = 1'b0; in_bcd_h = 4'd1; in_bcd_t = 4'd2; in_bcd_o = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", in_ready, 1);
    check("midrst out_valid", out_valid, 0);
    check("midrst out_bin", out_bin, 0);
    check("midrst out_ovf", out_ovf, 0);
    check("midrst out_bad", out_bad_digit, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("midrst no_emit", out_valid, 0);
    run_op("after_rst", 1'b0, 4'd0, 4'd9, 4'd9, 8'h63, 1'b0, 1'b0, 0, 1'b0);

    // reset while a result is waiting in DONE
    in_valid = 1'b1; in_sign = 1'b1; in_bcd_h = 4'd0; in_bcd_t = 4'd0; in_bcd_o = 4'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1; k++;
    end
    check("done_rst pre_bin", out_bin, 8'hF9);
    rst_n = 1'b0;
    #1;
    check("done_rst out_valid", out_valid, 0);
    check("done_rst out_bin", out_bin, 0);
    check("done_rst in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // shuffled sweep of every signed value
    for (int v = -999; v <= 999; v++) vals.push_back(v);
    for (int i = vals.size() - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = vals[i]; vals[i] = vals[j]; vals[j] = tmp;
    end
    foreach (vals[i]) begin
      sg  = (vals[i] < 0);
      mag = sg ? -vals[i] : vals[i];
      dh  = 4'(mag / 100); dt = 4'((mag / 10) % 10); dd = 4'(mag % 10);
      model(sg, dh, dt, dd, eb, eo, ebad);
      run_op($sformatf("sweep%0d", vals[i]), sg, dh, dt, dd, eb, eo, ebad,
             ($urandom_range(7, 0) == 0) ? 1 : 0, 1'b0);
    end

    for (int i = 0; i < 30; i++) begin
      sg = 1'($urandom);
      dh = 4'($urandom); dt = 4'($urandom); dd = 4'($urandom);
      case (i % 3)
        0: dh = 4'($urandom_range(15, 10));
        1: dt = 4'($urandom_range(15, 10));
        default: dd = 4'($urandom_range(15, 10));
      endcase
      model(sg, dh, dt, dd, eb, eo, ebad);
      run_op($sformatf("badrnd%0d", i), sg, dh, dt, dd, eb, eo, ebad, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
